// File: rtl/seq_div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Combinational trial subtractor: a - b as a + ~b + 1, with borrow = inverted carry-out.
module div_trial_sub #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow
);

  logic [WIDTH:0] w_sum;

  assign w_sum    = {1'b0, i_a} + {1'b0, ~i_b} + (WIDTH + 1)'(1);
  assign o_diff   = w_sum[WIDTH-1:0];
  assign o_borrow = ~w_sum[WIDTH];

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider, one quotient bit per clock, with start/busy/done handshake.
module seq_restoring_divider
  import seq_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = clog2(WIDTH);

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_q, r_rem, r_divisor;
  logic [WIDTH-1:0] r_quot, r_remain;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dbz;

  logic             w_accept, w_last, w_take, w_borrow;
  logic [WIDTH:0]   w_shifted, w_diff;
  logic [WIDTH-1:0] w_rem_next, w_q_next;

  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  // Partial remainder is always below the divisor, so its extra top bit is
  // structurally zero and only WIDTH bits are kept.
  assign w_shifted = {r_rem, r_q[WIDTH-1]};

  div_trial_sub #(
    .WIDTH(WIDTH + 1)
  ) u_trial_sub (
    .i_a     (w_shifted),
    .i_b     ({1'b0, r_divisor}),
    .o_diff  (w_diff),
    .o_borrow(w_borrow)
  );

  assign w_take     = ~w_diff[WIDTH] & ~w_borrow;
  assign w_rem_next = w_take ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
  assign w_q_next   = {r_q[WIDTH-2:0], w_take};

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) w_state_next = (divisor == '0) ? DONE : RUN;
      end
      RUN: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        if (start) w_state_next = (divisor == '0) ? DONE : RUN;
        else       w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q       <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
      r_quot    <= '0;
      r_remain  <= '0;
      r_dbz     <= 1'b0;
    end else if (w_accept) begin
      r_q       <= dividend;
      r_rem     <= '0;
      r_divisor <= divisor;
      r_cnt     <= '0;
      if (divisor == '0) begin
        r_quot   <= '1;
        r_remain <= dividend;
        r_dbz    <= 1'b1;
      end
    end else if (r_state == RUN) begin
      r_q   <= w_q_next;
      r_rem <= w_rem_next;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_quot   <= w_q_next;
        r_remain <= w_rem_next;
        r_dbz    <= 1'b0;
      end
    end
  end

  assign busy        = (r_state == RUN);
  assign done        = (r_state == DONE);
  assign quotient    = r_quot;
  assign remainder   = r_remain;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and exhaustive scoreboard bench for seq_restoring_divider (WIDTH=4).
module tb_seq_restoring_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  seq_restoring_divider #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one start pulse and record the expected result in the scoreboard.
  task automatic launch(input int dd, input int dv);
    exp_t e;
    dividend = W'(dd);
    divisor  = W'(dv);
    start    = 1'b1;
    if (dv == 0) begin
      e.q = '1;
      e.r = W'(dd);
      e.z = 1'b1;
    end else begin
      e.q = W'(dd / dv);
      e.r = W'(dd % dv);
      e.z = 1'b0;
    end
    sb.push_back(e);
    step();
    start = 1'b0;
  endtask

  // Waits (bounded) for done; cyc0 = samples already elapsed since the start edge.
  task automatic wait_done(input string tag, input int cyc0, input int exp_lat);
    int   cyc;
    exp_t e;
    cyc = cyc0;
    while (done !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
    check({tag, " latency"}, cyc, exp_lat);
    n_cmp++;
    assert (sb.size() > 0)
    else begin
      n_err++;
      $error("FAIL %s scoreboard: got empty expected entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, " quotient"}, quotient, e.q);
      check({tag, " remainder"}, remainder, e.r);
      check({tag, " div_by_zero"}, div_by_zero, e.z);
      check({tag, " busy@done"}, busy, 0);
    end
  endtask

  task automatic done_drops(input string tag);
    step();
    check({tag, " done one cycle"}, done, 0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    step();
    step();
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    check("reset dbz", div_by_zero, 0);
    rst = 1'b0;
    step();

    // 13/3: busy for exactly four samples, then done.
    launch(13, 3);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("13/3 busy c%0d", i), busy, 1);
      check($sformatf("13/3 no done c%0d", i), done, 0);
      if (i < 3) step();
    end
    wait_done("13/3", 4, 5);
    done_drops("13/3");

    launch(15, 1);  wait_done("15/1", 1, 5);   done_drops("15/1");
    launch(5, 7);   wait_done("5/7", 1, 5);    done_drops("5/7");
    launch(0, 9);   wait_done("0/9", 1, 5);    done_drops("0/9");
    launch(15, 15); wait_done("15/15", 1, 5);  done_drops("15/15");

    // Divide by zero: immediate done, busy never seen.
    launch(9, 0);
    check("9/0 busy", busy, 0);
    wait_done("9/0", 1, 1);
    done_drops("9/0");

    // Start during RUN is ignored; start in DONE is accepted back-to-back.
    launch(14, 4);
    step();
    dividend = 4'd7;
    divisor  = 4'd2;
    start    = 1'b1;
    step();
    start    = 1'b0;
    wait_done("14/4 ignore", 3, 5);
    launch(7, 2);
    check("b2b busy", busy, 1);
    check("b2b done low", done, 0);
    wait_done("7/2 b2b", 1, 5);
    done_drops("7/2 b2b");

    // Reset mid-RUN abandons the operation.
    launch(12, 5);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst quotient", quotient, 0);
    check("midrst remainder", remainder, 0);
    check("midrst dbz", div_by_zero, 0);
    void'(sb.pop_back());
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("midrst no done c%0d", i), done, 0);
    end
    launch(12, 5);  wait_done("12/5 restart", 1, 5);  done_drops("12/5 restart");

    // Exhaustive sweep with invariant checks.
    for (int dd = 0; dd < 16; dd++) begin
      for (int dv = 0; dv < 16; dv++) begin
        string tag;
        tag = $sformatf("sweep %0d/%0d", dd, dv);
        launch(dd, dv);
        wait_done(tag, 1, (dv == 0) ? 1 : 5);
        if (dv != 0) begin
          check({tag, " q*d+r"}, int'(quotient) * int'(divisor) + int'(remainder), dd);
          check({tag, " r<d"}, (remainder < divisor) ? 1 : 0, 1);
        end
        done_drops(tag);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
